// File: rtl/io_pkg.sv
// Shared types and helpers for the slow-input buffer: FSM states, default stop code, parity.
package io_pkg;

    typedef enum logic [2:0] {IDLE, RUN, HOLD, DRAIN, DONE} io_in_state_t;

    localparam logic [4:0] IO_STOP_CODE = 5'h10;

    // Bit that makes the total number of ones (data + this bit) odd.
    function automatic logic odd_parity(input logic [31:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/io_code_fifo.sv
// Synchronous code FIFO; a pop frees the slot so a write to a full FIFO in the same cycle lands.
module io_code_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_wr,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_rd,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_cnt;
    logic             w_rd;
    logic             w_wr;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_rd = i_rd & ~o_empty & ~i_flush;
    assign w_wr = i_wr & (~o_full | w_rd) & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage carries no reset; the head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/io_in_buffer.sv
// Multi-channel slow-input buffer: device select, motion throttling, stop detection, FIFO.
module io_in_buffer
    import io_pkg::*;
#(
    parameter int                NCHAN     = 4,
    parameter int                CODE_W    = 5,
    parameter int                DEPTH     = 8,
    parameter int                HOLD_LVL  = DEPTH - 2,
    parameter int                PARITY_EN = 0,
    parameter logic [CODE_W-1:0] STOP_CODE = CODE_W'(IO_STOP_CODE)
) (
    input  logic                                CLOCK,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [$clog2(NCHAN)-1:0]            chan_sel,
    input  logic [NCHAN*(CODE_W+PARITY_EN)-1:0] dev_code,
    input  logic [NCHAN-1:0]                    dev_strobe,
    output logic [NCHAN-1:0]                    dev_run,
    output logic [CODE_W-1:0]                   code,
    output logic                                code_valid,
    input  logic                                code_take,
    output logic [$clog2(DEPTH):0]              fifo_cnt,
    output logic                                stop_seen,
    output logic                                done,
    output logic                                overrun,
    output logic                                parity_err,
    input  logic                                clr_flags
);

    localparam int SEL_W  = $clog2(NCHAN);
    localparam int WORD_W = CODE_W + PARITY_EN;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] HOLD_HI = CNT_W'(HOLD_LVL);
    localparam logic [CNT_W-1:0] HOLD_LO = CNT_W'(HOLD_LVL - 1);

    io_in_state_t      r_state;
    io_in_state_t      w_next;
    logic              r_en_q;
    logic [SEL_W-1:0]  r_sel;
    logic              r_stop_seen;
    logic              r_overrun;
    logic              r_parity_err;

    logic              w_en_rise;
    logic [WORD_W-1:0] w_word;
    logic [CODE_W-1:0] w_data;
    logic              w_strobe;
    logic              w_wr_req;
    logic              w_stop_evt;
    logic              w_pop;
    logic              w_par_bad;
    logic              w_full;
    logic              w_empty;
    logic [CODE_W-1:0] w_head;
    logic [CNT_W-1:0]  w_cnt;

    assign w_en_rise  = enable & ~r_en_q;
    assign w_word     = dev_code[int'(r_sel) * WORD_W +: WORD_W];
    assign w_data     = w_word[CODE_W-1:0];
    assign w_strobe   = dev_strobe[r_sel];
    assign w_wr_req   = w_strobe & enable & ~r_stop_seen & ((r_state == RUN) | (r_state == HOLD));
    assign w_stop_evt = w_wr_req & (w_data == STOP_CODE);
    assign w_pop      = code_take & ~w_empty;

    generate
        if (PARITY_EN != 0) begin : g_parity
            assign w_par_bad = (w_word[WORD_W-1] != odd_parity(32'(w_data)));
        end else begin : g_no_parity
            assign w_par_bad = 1'b0;
        end
    endgenerate

    io_code_fifo #(
        .W     (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLOCK),
        .rst_n   (rst_n),
        .i_flush (~enable),
        .i_wr    (w_wr_req),
        .i_wdata (w_data),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_en_q       <= 1'b0;
            r_sel        <= '0;
            r_stop_seen  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en_q  <= enable;
            if (w_en_rise) r_sel <= chan_sel;
            if (!enable)         r_stop_seen <= 1'b0;
            else if (w_stop_evt) r_stop_seen <= 1'b1;
            // A set event in the same cycle as clr_flags must win.
            if (w_wr_req & w_full & ~w_pop) r_overrun <= 1'b1;
            else if (clr_flags)             r_overrun <= 1'b0;
            if (w_wr_req & w_par_bad) r_parity_err <= 1'b1;
            else if (clr_flags)       r_parity_err <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (w_en_rise) w_next = RUN;
                RUN: begin
                    if (w_stop_evt)            w_next = DRAIN;
                    else if (w_cnt >= HOLD_HI) w_next = HOLD;
                end
                // One entry of hysteresis keeps the device from chattering at the threshold.
                HOLD: begin
                    if (w_stop_evt)           w_next = DRAIN;
                    else if (w_cnt < HOLD_LO) w_next = RUN;
                end
                DRAIN: if (w_empty) w_next = DONE;
                DONE:  w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        dev_run = '0;
        if (r_state == RUN) dev_run[r_sel] = 1'b1;
    end

    assign code       = w_empty ? '0 : w_head;
    assign code_valid = ~w_empty;
    assign fifo_cnt   = w_cnt;
    assign stop_seen  = r_stop_seen;
    assign done       = (r_state == DONE);
    assign overrun    = r_overrun;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_io_in_buffer.sv
// Scoreboard bench for io_in_buffer: plain instance plus a parity-enabled instance.
module tb_io_in_buffer;

    logic        CLOCK = 1'b0;
    logic        rst_n;
    always #5 CLOCK = ~CLOCK;

    // Instance A: PARITY_EN=0
    logic        en, take, clr;
    logic [1:0]  sel;
    logic [19:0] dcode;
    logic [3:0]  dstb, run;
    logic [4:0]  code;
    logic        cv, stop, done, ovr, perr;
    logic [3:0]  cnt;

    // Instance B: PARITY_EN=1
    logic        b_en, b_take, b_clr;
    logic [1:0]  b_sel;
    logic [23:0] b_dcode;
    logic [3:0]  b_dstb, b_run;
    logic [4:0]  b_code;
    logic        b_cv, b_stop, b_done, b_ovr, b_perr;
    logic [3:0]  b_cnt;

    io_in_buffer #(.NCHAN(4), .CODE_W(5), .DEPTH(8), .PARITY_EN(0)) dut (
        .CLOCK(CLOCK), .rst_n(rst_n), .enable(en), .chan_sel(sel), .dev_code(dcode),
        .dev_strobe(dstb), .dev_run(run), .code(code), .code_valid(cv), .code_take(take),
        .fifo_cnt(cnt), .stop_seen(stop), .done(done), .overrun(ovr), .parity_err(perr),
        .clr_flags(clr));

    io_in_buffer #(.NCHAN(4), .CODE_W(5), .DEPTH(8), .PARITY_EN(1)) dut_p (
        .CLOCK(CLOCK), .rst_n(rst_n), .enable(b_en), .chan_sel(b_sel), .dev_code(b_dcode),
        .dev_strobe(b_dstb), .dev_run(b_run), .code(b_code), .code_valid(b_cv), .code_take(b_take),
        .fifo_cnt(b_cnt), .stop_seen(b_stop), .done(b_done), .overrun(b_ovr), .parity_err(b_perr),
        .clr_flags(b_clr));

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_c;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic strobe(input int ch, input logic [4:0] c);
        dcode = '0;
        dcode[ch*5 +: 5] = c;
        dstb = 4'b0001 << ch;
        tick();
        dstb = '0;
    endtask

    task automatic start_block(input logic [1:0] s);
        sel = s;
        en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 0; take = 0; clr = 0; sel = 0; dcode = '0; dstb = '0;
        b_en = 0; b_take = 0; b_clr = 0; b_sel = 0; b_dcode = '0; b_dstb = '0;
        repeat (2) tick();
        n_cmp++; if (run !== 4'b0000) begin n_err++; $display("FAIL reset_run: got %b expected 0000", run); end
        n_cmp++; if (cnt !== 4'd0 || cv !== 1'b0) begin n_err++; $display("FAIL reset_fifo: cnt %0d cv %b expected 0/0", cnt, cv); end
        n_cmp++; if ({code, stop, done, ovr, perr} !== 9'd0) begin n_err++; $display("FAIL reset_outs: got %h expected 0", {code, stop, done, ovr, perr}); end
        n_cmp++; if ({b_run, b_cnt, b_perr} !== 9'd0) begin n_err++; $display("FAIL reset_par_outs: got %h expected 0", {b_run, b_cnt, b_perr}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_block();
        start_block(2'd2);
        n_cmp++; if (run !== 4'b0100) begin n_err++; $display("FAIL basic_run: got %b expected 0100", run); end
        strobe(2, 5'h05); exp_q.push_back(5'h05);
        n_cmp++; if (cv !== 1'b1 || stop !== 1'b0) begin n_err++; $display("FAIL basic_first_valid: cv %b stop %b expected 1/0", cv, stop); end
        strobe(2, 5'h0A); exp_q.push_back(5'h0A);
        strobe(2, 5'h10); exp_q.push_back(5'h10);
        n_cmp++; if (stop !== 1'b1 || cnt !== 4'd3) begin n_err++; $display("FAIL basic_stop: stop %b cnt %0d expected 1/3", stop, cnt); end
        n_cmp++; if (run !== 4'b0000) begin n_err++; $display("FAIL basic_drain_run: got %b expected 0000", run); end
        strobe(2, 5'h07);
        n_cmp++; if (cnt !== 4'd3) begin n_err++; $display("FAIL basic_after_stop: cnt %0d expected 3", cnt); end
        for (int i = 0; i < 3; i++) begin
            exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
            n_cmp++; if (cv !== 1'b1 || code !== exp_c) begin n_err++; $display("FAIL basic_pop%0d: cv %b code %h expected 1/%h", i, cv, code, exp_c); end
            take = 1'b1; tick(); take = 1'b0;
        end
        for (int i = 0; i < 6 && done !== 1'b1; i++) tick();
        n_cmp++; if (done !== 1'b1 || cnt !== 4'd0) begin n_err++; $display("FAIL basic_done: done %b cnt %0d expected 1/0", done, cnt); end
        en = 1'b0; tick();
        n_cmp++; if (done !== 1'b0 || stop !== 1'b0) begin n_err++; $display("FAIL basic_disable: done %b stop %b expected 0/0", done, stop); end
    endtask

    task automatic test_ignore_channels();
        start_block(2'd2);
        strobe(0, 5'h01);
        strobe(1, 5'h02);
        strobe(3, 5'h03);
        sel = 2'd1;
        strobe(1, 5'h04);
        n_cmp++; if (cnt !== 4'd0 || run !== 4'b0100) begin n_err++; $display("FAIL ignore: cnt %0d run %b expected 0/0100", cnt, run); end
        strobe(2, 5'h07); exp_q.push_back(5'h07);
        exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
        n_cmp++; if (cnt !== 4'd1 || code !== exp_c) begin n_err++; $display("FAIL ignore_sel_kept: cnt %0d code %h expected 1/%h", cnt, code, exp_c); end
        en = 1'b0; tick();
    endtask

    task automatic test_hold_overrun();
        start_block(2'd1);
        for (int i = 1; i <= 6; i++) begin strobe(1, 5'(i)); exp_q.push_back(5'(i)); end
        n_cmp++; if (cnt !== 4'd6) begin n_err++; $display("FAIL hold_cnt: got %0d expected 6", cnt); end
        tick();
        n_cmp++; if (run !== 4'b0000) begin n_err++; $display("FAIL hold_run_drop: got %b expected 0000", run); end
        for (int i = 0; i < 2; i++) begin
            exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
            n_cmp++; if (code !== exp_c) begin n_err++; $display("FAIL hold_pop%0d: got %h expected %h", i, code, exp_c); end
            take = 1'b1; tick(); take = 1'b0;
            n_cmp++; if (run !== 4'b0000) begin n_err++; $display("FAIL hold_hyst%0d: got %b expected 0000", i, run); end
        end
        tick();
        n_cmp++; if (run !== 4'b0010 || cnt !== 4'd4) begin n_err++; $display("FAIL hold_resume: run %b cnt %0d expected 0010/4", run, cnt); end
        for (int i = 7; i <= 10; i++) begin strobe(1, 5'(i)); exp_q.push_back(5'(i)); end
        n_cmp++; if (cnt !== 4'd8 || ovr !== 1'b0) begin n_err++; $display("FAIL full: cnt %0d ovr %b expected 8/0", cnt, ovr); end
        clr = 1'b1;
        strobe(1, 5'h1F);
        clr = 1'b0;
        n_cmp++; if (ovr !== 1'b1 || cnt !== 4'd8) begin n_err++; $display("FAIL overrun_set_wins: ovr %b cnt %0d expected 1/8", ovr, cnt); end
        clr = 1'b1; tick(); clr = 1'b0;
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL overrun_clr: got %b expected 0", ovr); end
        exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
        n_cmp++; if (code !== exp_c) begin n_err++; $display("FAIL full_pop_head: got %h expected %h", code, exp_c); end
        take = 1'b1;
        strobe(1, 5'h0B); exp_q.push_back(5'h0B);
        take = 1'b0;
        n_cmp++; if (cnt !== 4'd8 || ovr !== 1'b0) begin n_err++; $display("FAIL full_wr_rd: cnt %0d ovr %b expected 8/0", cnt, ovr); end
        for (int i = 0; i < 8; i++) begin
            exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
            n_cmp++; if (cv !== 1'b1 || code !== exp_c) begin n_err++; $display("FAIL drain%0d: cv %b code %h expected 1/%h", i, cv, code, exp_c); end
            take = 1'b1; tick(); take = 1'b0;
        end
        n_cmp++; if (cnt !== 4'd0 || cv !== 1'b0) begin n_err++; $display("FAIL drain_empty: cnt %0d cv %b expected 0/0", cnt, cv); end
        en = 1'b0; tick();
        exp_q.delete();
    endtask

    task automatic test_parity();
        b_sel = 2'd0; b_en = 1'b1; tick();
        b_dcode = '0; b_dcode[5:0] = {1'b1, 5'h03}; b_dstb = 4'b0001; tick(); b_dstb = '0;
        exp_q.push_back(5'h03);
        n_cmp++; if (b_perr !== 1'b0) begin n_err++; $display("FAIL parity_good: got %b expected 0", b_perr); end
        b_dcode[5:0] = {1'b0, 5'h05}; b_dstb = 4'b0001; tick(); b_dstb = '0;
        exp_q.push_back(5'h05);
        n_cmp++; if (b_perr !== 1'b1 || b_cnt !== 4'd2) begin n_err++; $display("FAIL parity_bad: perr %b cnt %0d expected 1/2", b_perr, b_cnt); end
        for (int i = 0; i < 2; i++) begin
            exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
            n_cmp++; if (b_code !== exp_c) begin n_err++; $display("FAIL parity_pop%0d: got %h expected %h", i, b_code, exp_c); end
            b_take = 1'b1; tick(); b_take = 1'b0;
        end
        b_clr = 1'b1; tick(); b_clr = 1'b0;
        n_cmp++; if (b_perr !== 1'b0) begin n_err++; $display("FAIL parity_clr: got %b expected 0", b_perr); end
        b_en = 1'b0; tick();
    endtask

    task automatic test_flush_reset();
        start_block(2'd3);
        strobe(3, 5'h11); strobe(3, 5'h12); strobe(3, 5'h13);
        n_cmp++; if (cnt !== 4'd3) begin n_err++; $display("FAIL flush_fill: got %0d expected 3", cnt); end
        en = 1'b0; tick();
        n_cmp++; if (cnt !== 4'd0 || cv !== 1'b0 || run !== 4'b0000) begin n_err++; $display("FAIL flush: cnt %0d cv %b run %b expected 0/0/0000", cnt, cv, run); end
        start_block(2'd3);
        strobe(3, 5'h14);
        n_cmp++; if (run !== 4'b1000 || cnt !== 4'd1) begin n_err++; $display("FAIL rerun: run %b cnt %0d expected 1000/1", run, cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (run !== 4'b0000 || cnt !== 4'd0 || cv !== 1'b0 || code !== 5'h00) begin n_err++; $display("FAIL async_reset: run %b cnt %0d cv %b code %h expected all 0", run, cnt, cv, code); end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (run !== 4'b0000 || done !== 1'b0) begin n_err++; $display("FAIL reset_idle: run %b done %b expected 0000/0", run, done); end
    endtask

    initial begin
        test_reset();
        test_basic_block();
        test_ignore_channels();
        test_hold_overrun();
        test_parity();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
